seven_segment_readback: RTL and testbench
=========================================

Name: seven_segment_readback

Overview:
- Inverse of the hex-to-segment display decoder.
- Observes the multiplexed, common-anode, active-low display bus (one segment bus plus per-digit anode enables) and reconstructs the hex value shown on each digit.
- Commits a digit only after its pattern has been stable for a programmable number of cycles.
- Flags patterns that are not valid hex glyphs.
- Sits beside the display driver in the I/O subsystem; used for self-check and for bus read-back of what the display shows.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (anode lines).
- STABLE_CYCLES, 4: consecutive identical samples required before commit; legal range 1 to 255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- seg_i  input  7  segment bus, active-low, bit order {g,f,e,d,c,b,a}, synchronous to clk.
- anode_n_i  input  NUM_DIGITS  digit enables, active-low; bit k selects digit k.
- err_clr_i  input  1  one-cycle pulse that clears all error flags.
- hex_o  output  4*NUM_DIGITS  decoded nibbles; digit k occupies bits [4k+3:4k].
- valid_o  output  NUM_DIGITS  bit k set means digit k holds a committed hex value.
- err_o  output  NUM_DIGITS  sticky flag: an illegal glyph was committed on digit k.
- update_o  output  1  one-cycle pulse on any commit that changes hex_o, valid_o or err_o.

Behaviour:
- Reset (rst_n low at a clk edge) clears all outputs: hex_o=0, valid_o=0, err_o=0, update_o=0. It also sets FSM=IDLE and count=0. Reset mid-settle discards the pending sample.
- Legal glyphs, as seg_i values: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
- Blank glyph is 0x7F.
- Every other pattern is illegal.
- Sample pair = (index of the single active anode, seg_i). A sample pair is "selected" only when exactly one anode_n_i bit is 0.
- FSM states and transitions:
  - IDLE: no anode or more than one anode active. Stays IDLE until a selected sample appears, then goes to SETTLE with count=1 and the pair latched.
  - SETTLE: if the current pair equals the latched pair, count increments. When count reaches STABLE_CYCLES, the block commits on that same edge and goes to LOCKED.
    - A different selected pair reloads the latch, sets count=1 and stays in SETTLE.
    - An unselected cycle goes to IDLE.
  - LOCKED: holds while the pair is unchanged; no further commits. A different selected pair goes to SETTLE with count=1; an unselected cycle goes to IDLE.
- STABLE_CYCLES=1: commit on the first selected edge (IDLE goes straight to LOCKED).
- Latency: outputs update on the STABLE_CYCLES-th consecutive edge sampling the same pair.
- Commit actions for digit k:
  - Legal glyph: hex_o[k] is set to the nibble and valid_o[k] is set to 1.
  - Blank: valid_o[k] is set to 0 and hex_o[k] holds.
  - Illegal glyph: err_o[k] is set to 1; hex_o[k] and valid_o[k] hold.
- update_o is high for the single cycle after the commit edge, and only if some output bit changed.
- A commit identical to the stored state gives no pulse.
- err_clr_i clears all err_o bits. If it coincides with an illegal commit, the new error wins: that bit is set and the others are cleared.
- count saturates and never wraps. Its width is clog2(STABLE_CYCLES+1).
- Digits never addressed keep their reset values indefinitely.

Decomposition:
- Shared package seven_seg_pkg holds:
  - the 16-entry glyph constant array;
  - the SEG_BLANK constant (0x7F);
  - the FSM enum (IDLE, SETTLE, LOCKED).
- The glyph table is shared with the forward decoder so both directions use one source of truth.
- One natural sub-module, seven_segment_encoder: combinational seg[6:0] to {legal, blank, nibble[3:0]} lookup. The top holds the FSM, counter, digit registers and pulse logic.

Test Plan (NUM_DIGITS=4, STABLE_CYCLES=4):
- Reset then idle: anode_n_i=0xF for 10 cycles -> hex_o=0, valid_o=0, err_o=0, no update_o.
- Commit: anode_n_i=0xE, seg_i=0x24 held 4 cycles -> on the 4th edge hex_o[3:0]=2 and valid_o=0001; one update_o pulse; holding 10 more cycles gives no further pulse.
- Glitch reject: digit 1, seg_i=0x19 for 3 cycles, then 0x12 for 4 cycles -> hex_o[7:4]=5, never 4.
- Illegal and clear: digit 2, seg_i=0x7E for 4 cycles -> err_o=0100 and valid_o[2] unchanged. Then err_clr_i pulses concurrent with a digit-3 illegal commit -> err_o=1000.
- Ghosting: anode_n_i=0xC with any seg_i for 8 cycles -> no commit. Blank 0x7F on a valid digit 0 -> valid_o[0]=0 and hex_o[3:0] retained.
- Reset mid-settle: digit 0, seg_i=0x00 for 2 cycles, rst_n low for 1 cycle, then 3 more cycles -> no commit; commit occurs only after 4 cycles following reset.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display path (forward decoder and
// read-back). Segment patterns are common-anode, active-low, with bit order
// {g,f,e,d,c,b,a}.
//   GLYPHS    : segment pattern for each hex nibble 0..F (index = nibble)
//   SEG_BLANK : all segments off
//   state_t   : read-back settle FSM states
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Listed F down to 0 so that GLYPHS[n] is the pattern for nibble n.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOCKED
    } state_t;

endpackage

// File: rtl/seven_segment_encoder.sv
// Combinational segment-pattern to hex lookup (inverse of the glyph table).
//   seg    : 7-bit active-low segment pattern {g,f,e,d,c,b,a}
//   legal  : pattern is one of the 16 hex glyphs
//   blank  : pattern is the blank glyph (all segments off)
//   nibble : hex value of the glyph, 0 when not legal
module seven_segment_encoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic       blank,
    output logic [3:0] nibble
);

    logic [15:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign match[gi] = (seg == GLYPHS[gi]);
        end
    endgenerate

    // Glyphs are unique, so at most one match bit is ever set.
    always_comb begin
        nibble = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (match[i]) begin
                nibble = 4'(i);
            end
        end
    end

    assign legal = |match;
    assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seven_segment_readback.sv
// Read-back of a multiplexed common-anode seven-segment display bus.
// A (digit, pattern) pair is tracked while exactly one anode is active; once
// the same pair has been sampled STABLE_CYCLES consecutive edges it is
// committed to that digit's registers.
//   clk, rst_n  : clock, synchronous active-low reset
//   seg_i       : segment bus, active-low {g,f,e,d,c,b,a}
//   anode_n_i   : per-digit enables, active-low
//   err_clr_i   : clears all sticky error flags
//   hex_o       : decoded nibble per digit, digit k at [4k+3:4k]
//   valid_o     : digit holds a committed hex value
//   err_o       : sticky, illegal glyph committed on the digit
//   update_o    : one-cycle pulse after a commit that changed any output
module seven_segment_readback
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_i,
    input  logic [NUM_DIGITS-1:0]   anode_n_i,
    input  logic                    err_clr_i,
    output logic [4*NUM_DIGITS-1:0] hex_o,
    output logic [NUM_DIGITS-1:0]   valid_o,
    output logic [NUM_DIGITS-1:0]   err_o,
    output logic                    update_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

    state_t                    state_reg, state_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next, cnt_inc;
    logic [IDX_W-1:0]          lat_idx_reg, lat_idx_next;
    logic [6:0]                lat_seg_reg, lat_seg_next;
    logic [4*NUM_DIGITS-1:0]   hex_reg, hex_next;
    logic [NUM_DIGITS-1:0]     valid_reg, valid_next;
    logic [NUM_DIGITS-1:0]     err_reg, err_next;
    logic                      update_reg, update_next;

    logic [NUM_DIGITS-1:0]     act;
    logic                      sel;
    logic [IDX_W-1:0]          sel_idx;
    logic                      same_pair;
    logic                      commit;
    logic                      g_legal, g_blank;
    logic [3:0]                g_nibble;

    // Decode of the live sample; at a commit the live pair equals the latch.
    seven_segment_encoder u_enc (
        .seg    (seg_i),
        .legal  (g_legal),
        .blank  (g_blank),
        .nibble (g_nibble)
    );

    // A sample is only meaningful with exactly one anode driven; zero or
    // several active anodes (ghosting, blanking gaps) are ignored.
    assign act = ~anode_n_i;
    assign sel = (act != '0) && ((act & (act - NUM_DIGITS'(1))) == '0);

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (act[k]) begin
                sel_idx = IDX_W'(k);
            end
        end
    end

    assign same_pair = sel && (sel_idx == lat_idx_reg) && (seg_i == lat_seg_reg);
    assign cnt_inc   = (cnt_reg == CNT_TARGET) ? cnt_reg : cnt_reg + 1'b1;

    // Settle FSM: next state, counter, pair latch and commit strobe.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        lat_idx_next = lat_idx_reg;
        lat_seg_next = lat_seg_reg;
        commit       = 1'b0;
        if (!sel) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (state_reg != IDLE && same_pair) begin
            if (state_reg == SETTLE) begin
                cnt_next = cnt_inc;
                if (cnt_inc == CNT_TARGET) begin
                    commit     = 1'b1;
                    state_next = LOCKED;
                end
            end
            // LOCKED with an unchanged pair: hold, no repeat commit.
        end else begin
            // First sample of a new pair; counts as one stable sample.
            lat_idx_next = sel_idx;
            lat_seg_next = seg_i;
            cnt_next     = CNT_W'(1);
            if (STABLE_CYCLES == 1) begin
                commit     = 1'b1;
                state_next = LOCKED;
            end else begin
                state_next = SETTLE;
            end
        end
    end

    // Per-digit commit effect. A new illegal commit overrides a concurrent
    // error clear on its own digit only.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic hit;
            assign hit = commit && (sel_idx == IDX_W'(gi));

            assign hex_next[4*gi +: 4] = (hit && g_legal) ? g_nibble : hex_reg[4*gi +: 4];
            assign valid_next[gi]      = (hit && g_legal) ? 1'b1 :
                                         (hit && g_blank) ? 1'b0 : valid_reg[gi];
            assign err_next[gi]        = (hit && !g_legal && !g_blank) ? 1'b1 :
                                         (err_clr_i ? 1'b0 : err_reg[gi]);
        end
    endgenerate

    assign update_next = commit && ((hex_next != hex_reg) ||
                                    (valid_next != valid_reg) ||
                                    (err_next != err_reg));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            lat_idx_reg <= '0;
            lat_seg_reg <= SEG_BLANK;
            hex_reg     <= '0;
            valid_reg   <= '0;
            err_reg     <= '0;
            update_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            lat_idx_reg <= lat_idx_next;
            lat_seg_reg <= lat_seg_next;
            hex_reg     <= hex_next;
            valid_reg   <= valid_next;
            err_reg     <= err_next;
            update_reg  <= update_next;
        end
    end

    assign hex_o    = hex_reg;
    assign valid_o  = valid_reg;
    assign err_o    = err_reg;
    assign update_o = update_reg;

endmodule

// File: tb/tb_seven_segment_readback.sv
// Directed bench for seven_segment_readback (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seven_segment_readback;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_i;
    logic [3:0]  anode_n_i;
    logic        err_clr_i;
    logic [15:0] hex_o;
    logic [3:0]  valid_o;
    logic [3:0]  err_o;
    logic        update_o;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    seven_segment_readback #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_i     (seg_i),
        .anode_n_i (anode_n_i),
        .err_clr_i (err_clr_i),
        .hex_o     (hex_o),
        .valid_o   (valid_o),
        .err_o     (err_o),
        .update_o  (update_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n edges, sampling 1 time unit after each edge; update pulses
    // are one cycle wide so each high sample is one pulse.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (update_o) pulses++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        seg_i     = 7'h7F;
        anode_n_i = 4'hF;
        err_clr_i = 1'b0;
        tick(2);
        rst_n = 1'b1;
        check("reset_hex",   32'(hex_o),    32'h0);
        check("reset_valid", 32'(valid_o),  32'h0);
        check("reset_err",   32'(err_o),    32'h0);
        check("reset_update", 32'(update_o), 32'h0);

        // Idle bus: no digit selected.
        pulses = 0;
        tick(10);
        check("idle_hex",    32'(hex_o),   32'h0);
        check("idle_valid",  32'(valid_o), 32'h0);
        check("idle_pulses", 32'(pulses),  32'h0);

        // Digit 0 shows '2'; commit on the 4th edge.
        anode_n_i = 4'hE; seg_i = 7'h24;
        pulses = 0;
        tick(3);
        check("d0_pre_valid", 32'(valid_o), 32'h0);
        tick(1);
        check("d0_hex",     32'(hex_o),    32'h0002);
        check("d0_valid",   32'(valid_o),  32'h1);
        check("d0_update",  32'(update_o), 32'h1);
        pulses = 0;
        tick(10);
        check("d0_hold_pulses", 32'(pulses), 32'h0);
        check("d0_hold_hex",    32'(hex_o),  32'h0002);

        // Digit 1: '4' only 3 cycles, then '5' for 4 cycles.
        anode_n_i = 4'hD; seg_i = 7'h19;
        pulses = 0;
        tick(3);
        check("glitch_hex_a", 32'(hex_o), 32'h0002);
        seg_i = 7'h12;
        tick(3);
        check("glitch_hex_b", 32'(hex_o), 32'h0002);
        tick(1);
        check("d1_hex",    32'(hex_o),   32'h0052);
        check("d1_valid",  32'(valid_o), 32'h3);
        check("d1_pulses", 32'(pulses),  32'h1);

        // Digit 2: illegal pattern sets the sticky error only.
        anode_n_i = 4'hB; seg_i = 7'h7E;
        pulses = 0;
        tick(4);
        check("d2_err",    32'(err_o),   32'h4);
        check("d2_valid",  32'(valid_o), 32'h3);
        check("d2_hex",    32'(hex_o),   32'h0052);
        check("d2_pulses", 32'(pulses),  32'h1);

        // Digit 3 illegal commit coinciding with an error clear.
        anode_n_i = 4'h7; seg_i = 7'h7E;
        tick(3);
        check("d3_pre_err", 32'(err_o), 32'h4);
        err_clr_i = 1'b1;
        tick(1);
        err_clr_i = 1'b0;
        check("d3_err_clr_err", 32'(err_o), 32'h8);
        check("d3_update",      32'(update_o), 32'h1);

        // Ghosting: two anodes active never commits.
        anode_n_i = 4'hC; seg_i = 7'h40;
        pulses = 0;
        tick(8);
        check("ghost_hex",    32'(hex_o),   32'h0052);
        check("ghost_valid",  32'(valid_o), 32'h3);
        check("ghost_pulses", 32'(pulses),  32'h0);

        // Blank on digit 0 clears valid, keeps the nibble.
        anode_n_i = 4'hE; seg_i = 7'h7F;
        pulses = 0;
        tick(4);
        check("blank_valid",  32'(valid_o), 32'h2);
        check("blank_hex",    32'(hex_o),   32'h0052);
        check("blank_pulses", 32'(pulses),  32'h1);

        // Re-committing the stored value on digit 1 gives no pulse.
        anode_n_i = 4'hD; seg_i = 7'h12;
        pulses = 0;
        tick(4);
        check("same_pulses", 32'(pulses), 32'h0);
        check("same_hex",    32'(hex_o),  32'h0052);

        // Standalone error clear.
        anode_n_i = 4'hF;
        err_clr_i = 1'b1;
        pulses = 0;
        tick(1);
        err_clr_i = 1'b0;
        check("clr_err",    32'(err_o),  32'h0);
        check("clr_pulses", 32'(pulses), 32'h0);

        // Reset in the middle of settling discards the pending sample.
        anode_n_i = 4'hE; seg_i = 7'h00;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("mid_rst_hex",   32'(hex_o),   32'h0);
        check("mid_rst_valid", 32'(valid_o), 32'h0);
        tick(3);
        check("post_rst_3_valid", 32'(valid_o), 32'h0);
        tick(1);
        check("post_rst_4_hex",   32'(hex_o),   32'h0008);
        check("post_rst_4_valid", 32'(valid_o), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
